// File: rtl/soc_fifo_arb_pkg.sv
// Shared types and helpers for the SoC FIFO write arbiter and its round-robin picker.
package soc_fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Index width that stays legal for a single-entry set.
  function automatic int f_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/soc_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping modulo p_num.
module soc_rr_pick
  import soc_fifo_arb_pkg::*;
#(
  parameter int p_num = 4,
  localparam int c_w = f_id_width(p_num)
) (
  input  logic [p_num-1:0] i_req,
  input  logic [c_w-1:0]   i_ptr,
  output logic             o_found,
  output logic [c_w-1:0]   o_idx
);

  logic [c_w-1:0] w_cand [p_num];

  // Candidate index for each offset from the pointer, folded back into 0..p_num-1.
  generate
    for (genvar gi = 0; gi < p_num; gi++) begin : g_cand
      logic [c_w:0] w_sum;
      assign w_sum = {1'b0, i_ptr} + (c_w + 1)'(gi);
      assign w_cand[gi] = (w_sum >= (c_w + 1)'(p_num)) ? c_w'(w_sum - (c_w + 1)'(p_num))
                                                        : c_w'(w_sum);
    end
  endgenerate

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = p_num - 1; k >= 0; k--) begin
      if (i_req[w_cand[k]]) begin
        o_found = 1'b1;
        o_idx   = w_cand[k];
      end
    end
  end

endmodule

// File: rtl/soc_fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter sharing one FIFO write port between p_num_req producers.
module soc_fifo_wr_arbiter
  import soc_fifo_arb_pkg::*;
#(
  parameter int p_data_width = 8,
  parameter int p_num_req    = 4,
  parameter int p_max_burst  = 16
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [p_num_req-1:0]                i_req_valid,
  input  logic [p_num_req*p_data_width-1:0]   i_req_data,
  input  logic [p_num_req-1:0]                i_req_last,
  output logic [p_num_req-1:0]                o_req_ready,
  input  logic                                i_fifo_full,
  output logic                                o_fifo_wr_en,
  output logic [p_data_width-1:0]             o_fifo_wr_data,
  output logic                                o_grant_valid,
  output logic [f_id_width(p_num_req)-1:0]    o_grant_id,
  output logic                                o_burst_trunc
);

  localparam int c_id_w  = f_id_width(p_num_req);
  localparam int c_cnt_w = (p_max_burst > 0) ? $clog2(p_max_burst + 1) : 1;

  arb_state_t          r_state;
  logic [c_id_w-1:0]   r_grant_id;
  logic [c_id_w-1:0]   r_rr_ptr;
  logic [c_cnt_w-1:0]  r_burst_cnt;
  logic                r_trunc;

  logic                w_pick_found;
  logic [c_id_w-1:0]   w_pick_idx;
  logic                w_busy;
  logic                w_acc;
  logic                w_last;
  logic                w_at_max;
  logic [c_id_w-1:0]   w_rr_next;
  logic [p_data_width-1:0] w_req_words [p_num_req];

  soc_rr_pick #(
    .p_num (p_num_req)
  ) u_pick (
    .i_req   (i_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

  // Reset masks every output in its own cycle so an in-flight burst cannot write.
  assign w_busy   = (r_state == ARB_BUSY) && !i_rst;
  assign w_acc    = w_busy && !i_fifo_full && i_req_valid[r_grant_id];
  assign w_last   = i_req_last[r_grant_id];
  assign w_rr_next = (r_grant_id == c_id_w'(p_num_req - 1)) ? '0 : r_grant_id + 1'b1;

  generate
    for (genvar gi = 0; gi < p_num_req; gi++) begin : g_req
      assign w_req_words[gi] = i_req_data[gi*p_data_width +: p_data_width];
      assign o_req_ready[gi] = w_busy && !i_fifo_full && (r_grant_id == c_id_w'(gi));
    end
    if (p_max_burst > 0) begin : g_cap
      assign w_at_max = (r_burst_cnt == c_cnt_w'(p_max_burst - 1));
    end else begin : g_nocap
      assign w_at_max = 1'b0;
    end
  endgenerate

  assign o_fifo_wr_en   = w_acc;
  assign o_fifo_wr_data = i_rst ? '0 : w_req_words[r_grant_id];
  assign o_grant_valid  = w_busy;
  assign o_grant_id     = i_rst ? '0 : r_grant_id;
  assign o_burst_trunc  = r_trunc && !i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ARB_IDLE;
      r_grant_id  <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_trunc     <= 1'b0;
    end else begin
      r_trunc <= 1'b0;
      if (r_state == ARB_IDLE) begin
        if (w_pick_found) begin
          r_grant_id  <= w_pick_idx;
          r_burst_cnt <= '0;
          r_state     <= ARB_BUSY;
        end
      end else if (w_acc) begin
        if (w_last || w_at_max) begin
          r_state     <= ARB_IDLE;
          r_burst_cnt <= '0;
          r_rr_ptr    <= w_rr_next;
          r_trunc     <= !w_last;
        end else begin
          r_burst_cnt <= r_burst_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_soc_fifo_wr_arbiter.sv
// Bench for soc_fifo_wr_arbiter with a depth-8 behavioural FIFO, directed tables and a random run.
module tb_soc_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int FIFO_DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            wr_en;
  logic [DW-1:0]   wr_data;
  logic            grant_valid;
  logic [1:0]      grant_id;
  logic            burst_trunc;

  always #5 clk = ~clk;

  soc_fifo_wr_arbiter #(
    .p_data_width (DW),
    .p_num_req    (N),
    .p_max_burst  (MB)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .i_req_data     (req_data),
    .i_req_last     (req_last),
    .o_req_ready    (req_ready),
    .i_fifo_full    (fifo_full),
    .o_fifo_wr_en   (wr_en),
    .o_fifo_wr_data (wr_data),
    .o_grant_valid  (grant_valid),
    .o_grant_id     (grant_id),
    .o_burst_trunc  (burst_trunc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural FIFO state and sampled DUT outputs.
  logic [7:0] fifo_q [$];
  logic [7:0] rd_log [$];
  logic       use_fifo = 1'b0;
  logic       tb_full  = 1'b0;
  logic       tb_rd    = 1'b0;
  logic [N-1:0] s_ready;
  logic       s_wr, s_gv, s_trunc;
  logic [7:0] s_data;
  logic [1:0] s_gid;

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic [3:0] last;
    logic [3:0] e_ready;
    logic       e_wr;
    logic [7:0] e_data;
    logic       e_gv;
    logic [1:0] e_gid;
    logic       e_trunc;
  } vec_t;

  vec_t vt [$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic addv(input logic r, input logic [3:0] v, input logic [3:0] l,
                      input logic [3:0] rdy, input logic w, input logic [7:0] d,
                      input logic gv, input logic [1:0] g, input logic t);
    vec_t e;
    e.rst = r; e.valid = v; e.last = l; e.e_ready = rdy; e.e_wr = w;
    e.e_data = d; e.e_gv = gv; e.e_gid = g; e.e_trunc = t;
    vt.push_back(e);
  endtask

  // One clock: sample outputs on the falling edge, advance, then update the FIFO model.
  task automatic cycle();
    int pre;
    @(negedge clk);
    s_ready = req_ready; s_wr = wr_en; s_data = wr_data;
    s_gv = grant_valid; s_gid = grant_id; s_trunc = burst_trunc;
    @(posedge clk);
    #1;
    if (use_fifo) begin
      pre = fifo_q.size();
      if (tb_rd && pre > 0) rd_log.push_back(fifo_q.pop_front());
      if (s_wr) begin
        chk("fifo_no_overflow", int'(pre < FIFO_DEPTH), 1);
        fifo_q.push_back(s_data);
      end
      fifo_full = (fifo_q.size() >= FIFO_DEPTH);
    end else begin
      fifo_full = tb_full;
    end
  endtask

  task automatic set_word(input int k, input logic [7:0] d);
    req_data[k*DW +: DW] = d;
  endtask

  // Reference model state for the random run.
  int m_owner, m_words, m_ptr;
  bit m_trunc;

  initial begin
    logic [7:0] exp_l [9];
    int wcount;
    logic [7:0] d0;

    rst = 1'b1; req_valid = '0; req_last = '0; fifo_full = 1'b0;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // rst, valid, last, ready, wr, data, gv, gid, trunc
    for (int i = 0; i < 3; i++) addv(1, 4'hF, 4'hF, 4'h0, 0, 8'h00, 0, 0, 0);
    addv(0, 4'hF, 4'hF, 4'h0, 0, 8'h00, 0, 0, 0);
    addv(0, 4'hF, 4'hF, 4'h1, 1, 8'hA0, 1, 0, 0);
    addv(0, 4'hF, 4'hF, 4'h0, 0, 8'h00, 0, 0, 0);
    addv(0, 4'hF, 4'hF, 4'h2, 1, 8'hA1, 1, 1, 0);
    addv(0, 4'hF, 4'hF, 4'h0, 0, 8'h00, 0, 0, 0);
    addv(0, 4'hF, 4'hF, 4'h4, 1, 8'hA2, 1, 2, 0);
    addv(0, 4'hF, 4'hF, 4'h0, 0, 8'h00, 0, 0, 0);
    addv(0, 4'hF, 4'hF, 4'h8, 1, 8'hA3, 1, 3, 0);
    addv(0, 4'hF, 4'hF, 4'h0, 0, 8'h00, 0, 0, 0);
    addv(0, 4'hF, 4'hF, 4'h1, 1, 8'hA0, 1, 0, 0);
    addv(0, 4'h0, 4'h0, 4'h0, 0, 8'h00, 0, 0, 0);
    addv(0, 4'h4, 4'h0, 4'h0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 4; i++) addv(0, 4'h4, 4'h0, 4'h4, 1, 8'hA2, 1, 2, 0);
    addv(0, 4'h4, 4'h0, 4'h0, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 2; i++) addv(0, 4'h4, 4'h0, 4'h4, 1, 8'hA2, 1, 2, 0);
    addv(0, 4'h0, 4'h0, 4'h4, 0, 8'h00, 1, 2, 0);

    foreach (vt[i]) begin
      rst = vt[i].rst; req_valid = vt[i].valid; req_last = vt[i].last;
      cycle();
      chk($sformatf("tbl%0d_ready", i), s_ready, vt[i].e_ready);
      chk($sformatf("tbl%0d_wr_en", i), s_wr, vt[i].e_wr);
      chk($sformatf("tbl%0d_grant_valid", i), s_gv, vt[i].e_gv);
      chk($sformatf("tbl%0d_trunc", i), s_trunc, vt[i].e_trunc);
      if (vt[i].e_wr) chk($sformatf("tbl%0d_wr_data", i), s_data, vt[i].e_data);
      if (vt[i].e_gv) chk($sformatf("tbl%0d_grant_id", i), s_gid, vt[i].e_gid);
    end

    // Full backpressure mid-burst.
    rst = 1'b1; req_valid = '0; req_last = '0;
    cycle(); cycle();
    rst = 1'b0; use_fifo = 1'b1; fifo_q.delete(); rd_log.delete();
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h10 + i));
    fifo_full = 1'b0;
    d0 = 8'hC0; set_word(0, d0); req_valid = 4'h1;
    cycle();
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("full_fill_wr", s_wr, 1);
      chk("full_fill_data", s_data, d0);
      d0++; set_word(0, d0);
    end
    chk("full_flag_set", fifo_full, 1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("full_ready0", s_ready, 0);
      chk("full_wr0", s_wr, 0);
      chk("full_grant_held", s_gv, 1);
    end
    tb_rd = 1'b1; cycle(); tb_rd = 1'b0;
    chk("full_wr_during_pop", s_wr, 0);
    wcount = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (s_wr) begin wcount++; d0++; set_word(0, d0); end
    end
    chk("full_one_write_after_read", wcount, 1);
    req_valid = '0; tb_rd = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    tb_rd = 1'b0;
    exp_l = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'hC0, 8'hC1, 8'hC2};
    chk("full_drain_count", rd_log.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < rd_log.size()) chk($sformatf("full_drain%0d", i), rd_log[i], exp_l[i]);

    // Owner stall keeps the grant; fairness resumes after it.
    rst = 1'b1; cycle(); cycle();
    rst = 1'b0; tb_rd = 1'b1;
    set_word(1, 8'hD1); set_word(3, 8'hD3);
    req_valid = 4'b0010; req_last = '0;
    cycle();
    req_valid = 4'b1010;
    cycle();
    chk("stall_first_wr", s_wr, 1);
    chk("stall_first_gid", s_gid, 1);
    req_valid = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_hold_gv", s_gv, 1);
      chk("stall_hold_gid", s_gid, 1);
      chk("stall_hold_wr", s_wr, 0);
    end
    req_valid = 4'b1010; req_last = 4'b0010;
    cycle();
    chk("stall_last_wr", s_wr, 1);
    chk("stall_last_data", s_data, 8'hD1);
    req_valid = 4'b1011; req_last = '0;
    cycle();
    chk("stall_gap_idle", s_gv, 0);
    cycle();
    chk("stall_next_gv", s_gv, 1);
    chk("stall_next_gid", s_gid, 3);

    // Reset on the second word of a burst.
    req_valid = '0; rst = 1'b1; cycle(); cycle();
    rst = 1'b0; req_valid = 4'b0110; req_last = 4'b0010;
    cycle(); cycle();
    chk("rstmid_rel1_wr", s_wr, 1);
    req_last = '0;
    cycle(); cycle();
    chk("rstmid_word1_gid", s_gid, 2);
    chk("rstmid_word1_wr", s_wr, 1);
    rst = 1'b1;
    cycle();
    chk("rstmid_no_wr", s_wr, 0);
    chk("rstmid_ready", s_ready, 0);
    chk("rstmid_gv", s_gv, 0);
    rst = 1'b0; req_valid = 4'hF;
    cycle();
    chk("rstmid_idle", s_gv, 0);
    cycle();
    chk("rstmid_ptr_zero", s_gid, 0);

    // Random run against the transaction-level model.
    rst = 1'b1; req_valid = '0; cycle();
    m_owner = -1; m_words = 0; m_ptr = 0; m_trunc = 0;
    fifo_q.delete();
    for (int c = 0; c < 1500; c++) begin
      bit e_gv, e_wr, nt, found;
      int e_ready, own;
      logic [7:0] e_data;
      rst = ($urandom_range(0, 63) == 0);
      req_valid = 4'($urandom_range(0, 15));
      req_data = $urandom();
      for (int k = 0; k < N; k++) req_last[k] = ($urandom_range(0, 3) == 0);
      tb_rd = ($urandom_range(0, 9) < 4);
      own = m_owner;
      e_gv = !rst && (own >= 0);
      e_wr = e_gv && !fifo_full && req_valid[own];
      e_ready = (e_gv && !fifo_full) ? (1 << own) : 0;
      e_data = e_wr ? req_data[own*DW +: DW] : 8'h00;
      cycle();
      chk("rnd_ready", s_ready, e_ready);
      chk("rnd_wr_en", s_wr, e_wr);
      chk("rnd_grant_valid", s_gv, e_gv);
      chk("rnd_trunc", s_trunc, !rst && m_trunc);
      if (e_wr) chk("rnd_wr_data", s_data, e_data);
      if (e_gv) chk("rnd_grant_id", s_gid, own);
      if (rst) begin
        m_owner = -1; m_words = 0; m_ptr = 0; m_trunc = 0;
      end else begin
        nt = 0;
        if (own < 0) begin
          found = 0;
          for (int k = 0; k < N; k++)
            if (!found && req_valid[(m_ptr + k) % N]) begin
              found = 1; m_owner = (m_ptr + k) % N;
            end
          m_words = 0;
        end else if (e_wr) begin
          m_words++;
          if (req_last[own] || m_words == MB) begin
            nt = !req_last[own];
            m_ptr = (own + 1) % N;
            m_owner = -1;
            m_words = 0;
          end
        end
        m_trunc = nt;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
